// File: rtl/dac_frame_rx.sv
// Receives 32-bit DAC command frames from an asynchronous SPI-style link and models the DAC register.
// Result pulses appear 4 clk after dac_cs is sampled high at the pin; the block never applies backpressure.
module dac_frame_rx #(
   parameter logic [3:0] CHANNEL = 4'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        dac_cs,
   input  logic        dac_clr,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [3:0]  cmd,
   output logic [3:0]  addr,
   output logic [11:0] data,
   output logic [11:0] dac_value,
   output logic        update
);

   typedef enum logic [1:0] {IDLE, WAIT_HIGH, RECV, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  sck_sync, mosi_sync, cs_sync, clr_sync;
   logic        sck_d, cs_d;
   logic        sck_rise_q, cs_rise_q, cs_fall_q, mosi_q;
   logic [1:0]  settle;
   logic [5:0]  count;
   logic [31:0] sr;
   logic [11:0] pending;
   logic        clr_frame, shift_en, done_ok, done_bad;
   logic        addr_hit;

   assign addr_hit = (sr[19:16] == CHANNEL) || (sr[19:16] == 4'hF);

   // Edge pulses are registered so every event lines up with the delayed mosi sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sck_sync   <= 2'b11;
         mosi_sync  <= 2'b11;
         cs_sync    <= 2'b11;
         clr_sync   <= 2'b11;
         sck_d      <= 1'b1;
         cs_d       <= 1'b1;
         sck_rise_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
         mosi_q     <= 1'b0;
         settle     <= 2'd0;
      end else begin
         sck_sync   <= {sck_sync[0], spi_sck};
         mosi_sync  <= {mosi_sync[0], spi_mosi};
         cs_sync    <= {cs_sync[0], dac_cs};
         clr_sync   <= {clr_sync[0], dac_clr};
         sck_d      <= sck_sync[1];
         cs_d       <= cs_sync[1];
         sck_rise_q <= sck_sync[1] & ~sck_d;
         cs_rise_q  <= cs_sync[1] & ~cs_d;
         cs_fall_q  <= ~cs_sync[1] & cs_d;
         mosi_q     <= mosi_sync[1];
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= WAIT_HIGH;
      else      state <= state_nxt;
   end

   // WAIT_HIGH ignores the reset-forced synchronizer value until the pin level has propagated.
   always_comb begin
      state_nxt = state;
      clr_frame = 1'b0;
      shift_en  = 1'b0;
      done_ok   = 1'b0;
      done_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall_q) begin
               state_nxt = RECV;
               clr_frame = 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (settle[1] && cs_sync[1]) state_nxt = IDLE;
         end
         RECV: begin
            shift_en = sck_rise_q;
            if (cs_rise_q) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
            done_ok   = (count == 6'd32);
            done_bad  = (count != 6'd32);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         update      <= 1'b0;
         cmd         <= 4'h0;
         addr        <= 4'h0;
         data        <= 12'h000;
         dac_value   <= 12'h000;
         pending     <= 12'h000;
         count       <= 6'd0;
         sr          <= 32'h0;
      end else begin
         frame_valid <= done_ok;
         frame_err   <= done_bad;
         update      <= 1'b0;

         if (clr_frame) begin
            count <= 6'd0;
            sr    <= 32'h0;
         end else if (shift_en) begin
            sr <= (sr << 1) | {31'd0, mosi_q};
            if (count != 6'd33) count <= count + 6'd1;
         end

         if (done_ok) begin
            cmd  <= sr[23:20];
            addr <= sr[19:16];
            data <= sr[15:4];
         end

         // Clear wins over any command landing in the same cycle.
         if (!clr_sync[1]) begin
            pending   <= 12'h000;
            dac_value <= 12'h000;
         end else if (done_ok && addr_hit) begin
            case (sr[23:20])
               4'b0000: pending <= sr[15:4];
               4'b0001: begin
                  dac_value <= pending;
                  update    <= 1'b1;
               end
               4'b0011: begin
                  pending   <= sr[15:4];
                  dac_value <= sr[15:4];
                  update    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/dac_frame_rx.md
DAC_FRAME_RX -- requirements
Module: dac_frame_rx

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'h0, meaning the DAC address this block answers to; a frame address of 4'hF always matches.
REQ-002 SHALL have port clk, input, 1, the single system clock; every flop is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port spi_sck, input, 1, serial clock from the DAC driver, asynchronous to clk.
REQ-005 SHALL have port spi_mosi, input, 1, serial data, MSB first, asynchronous.
REQ-006 SHALL have port dac_cs, input, 1, active-low frame select, asynchronous.
REQ-007 SHALL have port dac_clr, input, 1, active-low DAC clear, asynchronous.
REQ-008 SHALL have port frame_valid, output, 1, one-cycle pulse marking a well-formed 32-bit frame.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse marking a frame whose bit count was not exactly 32.
REQ-010 SHALL have port cmd, output, 4, command field of the last valid frame.
REQ-011 SHALL have port addr, output, 4, address field of the last valid frame.
REQ-012 SHALL have port data, output, 12, data field of the last valid frame.
REQ-013 SHALL have port dac_value, output, 12, modelled DAC output register.
REQ-014 SHALL have port update, output, 1, one-cycle pulse when dac_value is loaded.

Function
REQ-015 SHALL pass spi_sck, spi_mosi, dac_cs and dac_clr through 2-flop synchronizers; all edge detection uses the synchronized copies and their one-cycle-delayed values.
REQ-016 SHALL implement FSM states IDLE, WAIT_HIGH, RECV and DONE.
REQ-017 IDLE: synchronized dac_cs falling edge -> RECV, clear the bit counter and shift register.
REQ-018 WAIT_HIGH: entered after reset when synchronized dac_cs is low; stays there until dac_cs is high, then -> IDLE; no bits are captured.
REQ-019 RECV: each synchronized spi_sck rising edge shifts synchronized spi_mosi into bit 0 of a 32-bit shift register and increments the 6-bit bit counter, which saturates at 33.
REQ-020 RECV: synchronized dac_cs rising edge -> DONE; spi_sck edges outside RECV are ignored.
REQ-021 DONE (one cycle): if count == 32, pulse frame_valid and load cmd = sr[23:20], addr = sr[19:16], data = sr[15:4]; bits [31:24] and [3:0] are ignored.
REQ-022 DONE: if count != 32 (including 0 and over 32), pulse frame_err only; cmd/addr/data are held; then -> IDLE.
REQ-023 frame_valid and frame_err SHALL never assert in the same cycle.
REQ-024 Latency: frame_valid/frame_err SHALL assert exactly 4 clk cycles after the first clk edge that samples dac_cs high at the pin.
REQ-025 On a valid frame with an address match, commands act in the DONE cycle, with results visible the next cycle: 4'b0000 loads the pending register with data; 4'b0001 copies pending into dac_value and pulses update; 4'b0011 loads both pending and dac_value with data and pulses update; all other commands have no effect.
REQ-026 Address mismatch SHALL still pulse frame_valid but SHALL NOT change pending, dac_value or update.
REQ-027 While synchronized dac_clr is low, pending and dac_value SHALL be forced to 0 and update SHALL stay low; frame reception and frame_valid/frame_err continue normally; dac_clr has priority over any simultaneous command.
REQ-028 Correct capture SHALL be guaranteed only when spi_sck high and low phases are each at least 2 clk periods, and dac_cs setup/hold around spi_sck edges is at least 2 clk periods.

Reset
REQ-029 With rst low at a clk edge: frame_valid=0, frame_err=0, update=0, cmd=0, addr=0, data=0, dac_value=0, pending=0, counter=0, synchronizers=1; next state is WAIT_HIGH.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse; capture resumes only after dac_cs is seen high and then falls.

Verification
REQ-031 CHANNEL=0; frame 32'h0030_ABC0 (cmd 3, addr 0, data 12'hABC) -> frame_valid 1 cycle, data=12'hABC, dac_value=12'hABC, update pulse.
REQ-032 Frame cmd 0 addr F data 12'h123, then cmd 1 addr 0 -> dac_value stays unchanged after the first frame, then becomes 12'h123 with update on the second.
REQ-033 31-bit and 33-bit frames -> frame_err pulse for each, no frame_valid, cmd/addr/data/dac_value unchanged.
REQ-034 Frame cmd 3 addr 2 with CHANNEL=0 -> frame_valid pulse, addr=2, dac_value unchanged, no update.
REQ-035 dac_clr held low during a cmd 3 frame -> frame_valid pulses, dac_value=0, no update; after dac_clr rises the next cmd 3 frame loads normally.
REQ-036 rst pulsed after 16 bits with dac_cs still low -> no pulses; the rest of that frame is ignored; the next full frame is received correctly.
